// File: rtl/uart_image_sender.sv
// Purpose: streams a WIDTH x HEIGHT frame from SDRAM read FIFO 2 to a Uart8 transmitter as R, G, B bytes per pixel.
// Latency: FIFO pop to first txStart is 4 cycles (READ, WAIT_READ, CONVERT, WAIT_CONVERT); after Blue, 2 cycles to the next pop.
// Backpressure: txStart is held in SEND until txBusy rises, then the byte waits in WAIT_SEND until txBusy falls.
// Config: define IMAGE_SENDER_GRAY_EN for grayscale (R=G=B=pixel[9:2]); default is the R, R+1, R+2 test pattern.
module uart_image_sender #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sdram_rd2_data,
  output logic       sdram_rd2_clk,
  output logic       sdram_rd2_load,
  input  logic       en,
  output logic [7:0] tx_data,
  output logic       txEn,
  output logic       txStart,
  input  logic       txDone,
  input  logic       txBusy,
  input  logic       READ_Request,
  input  logic       VGA_HS,
  input  logic       VGA_VS
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {
    RDY          = 3'd0,
    READ         = 3'd1,
    WAIT_READ    = 3'd2,
    CONVERT      = 3'd3,
    WAIT_CONVERT = 3'd4,
    SEND         = 3'd5,
    WAIT_SEND    = 3'd6,
    DONE         = 3'd7
  } state_t;

  state_t           present_state;
  state_t           next_state;
  logic [9:0]       pixel;
  logic [7:0]       red;
  logic [7:0]       green;
  logic [7:0]       blue;
  logic [7:0]       conv_red;
  logic [7:0]       conv_green;
  logic [7:0]       conv_blue;
  logic [7:0]       byte_sel;
  logic [1:0]       color_sel;
  logic [CNT_W-1:0] pix_cnt;
  logic             frame_end;
  logic [1:0]       unused_pixel_bits;
  logic             unused_inputs;

  // The FIFO is clocked from the same clock as this block.
  assign sdram_rd2_clk = clk;

  assign frame_end = (pix_cnt == CNT_W'(TOTAL));

`ifdef IMAGE_SENDER_GRAY_EN
  assign conv_red          = pixel[9:2];
  assign conv_green        = pixel[9:2];
  assign conv_blue         = pixel[9:2];
  assign unused_pixel_bits = pixel[1:0];
`else
  assign conv_red          = pixel[7:0];
  assign conv_green        = pixel[7:0] + 8'd1;
  assign conv_blue         = pixel[7:0] + 8'd2;
  assign unused_pixel_bits = pixel[9:8];
`endif

  // Uart8 done and the video/request strobes play no part in sequencing.
  assign unused_inputs = &{1'b0, txDone, READ_Request, VGA_HS, VGA_VS, unused_pixel_bits};

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) present_state <= RDY;
    else        present_state <= next_state;
  end

  // Next-state: one pixel per READ, three byte handshakes per pixel.
  always_comb begin
    next_state = present_state;
    case (present_state)
      RDY:          if (en) next_state = READ;
      READ:         next_state = (!en || frame_end) ? DONE : WAIT_READ;
      WAIT_READ:    next_state = CONVERT;
      CONVERT:      next_state = WAIT_CONVERT;
      WAIT_CONVERT: next_state = SEND;
      SEND: begin
        if (color_sel == 2'd3) next_state = READ;
        else if (txBusy)       next_state = WAIT_SEND;
      end
      WAIT_SEND:    if (!txBusy) next_state = SEND;
      DONE:         next_state = RDY;
      default:      next_state = RDY;
    endcase
  end

  // Datapath: pixel capture, colour conversion, byte index and pixel counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel     <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      color_sel <= '0;
      pix_cnt   <= '0;
    end else begin
      case (present_state)
        RDY: begin
          pix_cnt   <= '0;
          color_sel <= '0;
        end
        WAIT_READ: pixel <= sdram_rd2_data;
        CONVERT: begin
          red   <= conv_red;
          green <= conv_green;
          blue  <= conv_blue;
        end
        SEND: begin
          if (color_sel == 2'd3) begin
            color_sel <= '0;
            pix_cnt   <= pix_cnt + CNT_W'(1);
          end
        end
        WAIT_SEND: if (!txBusy) color_sel <= color_sel + 2'd1;
        default: ;
      endcase
    end
  end

  // Byte currently addressed by color_sel.
  always_comb begin
    byte_sel = 8'd0;
    case (color_sel)
      2'd0:    byte_sel = red;
      2'd1:    byte_sel = green;
      2'd2:    byte_sel = blue;
      default: byte_sel = 8'd0;
    endcase
  end

  // Outputs decoded from state; pop is suppressed when READ is about to stop.
  always_comb begin
    sdram_rd2_load = 1'b0;
    txEn           = 1'b0;
    txStart        = 1'b0;
    tx_data        = 8'd0;
    case (present_state)
      READ: sdram_rd2_load = en && !frame_end;
      SEND: begin
        if (color_sel != 2'd3) begin
          txEn    = 1'b1;
          txStart = 1'b1;
          tx_data = byte_sel;
        end
      end
      WAIT_SEND: begin
        txEn    = 1'b1;
        tx_data = byte_sel;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_image_sender.sv
// Bench for uart_image_sender with a 10x1 frame: random pixels, a behavioural FIFO and Uart8,
// byte stream compared against the colour rules, plus stop, restart and mid-frame reset cases.
module tb_uart_image_sender;

  localparam int WIDTH  = 10;
  localparam int HEIGHT = 1;
  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int BUDGET = 5000;

  logic       clk;
  logic       rst_n;
  logic [9:0] sdram_rd2_data;
  logic       sdram_rd2_clk;
  logic       sdram_rd2_load;
  logic       en;
  logic [7:0] tx_data;
  logic       txEn;
  logic       txStart;
  logic       txDone;
  logic       txBusy;
  logic       READ_Request;
  logic       VGA_HS;
  logic       VGA_VS;

  int         vec_cnt;
  int         err_cnt;
  logic [9:0] pix [TOTAL];
  logic [7:0] got_q [$];
  int         pop_idx;
  logic       load_d;
  int         busy_left;
  int         watch;

  uart_image_sender #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sdram_rd2_data (sdram_rd2_data),
    .sdram_rd2_clk  (sdram_rd2_clk),
    .sdram_rd2_load (sdram_rd2_load),
    .en             (en),
    .tx_data        (tx_data),
    .txEn           (txEn),
    .txStart        (txStart),
    .txDone         (txDone),
    .txBusy         (txBusy),
    .READ_Request   (READ_Request),
    .VGA_HS         (VGA_HS),
    .VGA_VS         (VGA_VS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Colour rule: byte c (0=R,1=G,2=B) of a pixel.
  function automatic logic [7:0] exp_byte(input logic [9:0] p, input int c);
`ifdef IMAGE_SENDER_GRAY_EN
    return 8'(int'(p) / 4);
`else
    return 8'((int'(p) % 256 + c) % 256);
`endif
  endfunction

  function automatic logic [31:0] st();
    return 32'(dut.present_state);
  endfunction

  task automatic init_model();
    got_q.delete();
    pop_idx   = 0;
    load_d    = 1'b0;
    txBusy    = 1'b0;
    txDone    = 1'b0;
    busy_left = 0;
    watch     = 0;
    for (int i = 0; i < TOTAL; i++) pix[i] = 10'($urandom);
  endtask

  // One clock: models act at the falling edge, away from the DUT's active edge.
  task automatic step();
    @(negedge clk);
    // After the Blue byte completes: one SEND cycle without a strobe, then READ.
    if (watch == 2) begin
      check("after_blue_read", st(), 32'd1);
      watch = 0;
    end else if (watch == 1) begin
      check("after_blue_send", st(), 32'd5);
      check("after_blue_nostart", 32'(txStart), 32'd0);
      watch = 2;
    end
    // Uart8: accepts a byte on txEn&txStart while idle, stays busy a random time.
    txDone = 1'b0;
    if (txBusy) begin
      busy_left--;
      if (busy_left == 0) begin
        txBusy = 1'b0;
        txDone = 1'b1;
        if (got_q.size() % 3 == 0) watch = 1;
      end
    end else if (txEn && txStart) begin
      got_q.push_back(tx_data);
      txBusy    = 1'b1;
      busy_left = $urandom_range(1, 6);
    end
    // FIFO: data valid the cycle after the pop, garbage otherwise.
    if (load_d) begin
      sdram_rd2_data = (pop_idx < TOTAL) ? pix[pop_idx] : 10'h3FF;
      pop_idx++;
    end else begin
      sdram_rd2_data = 10'($urandom);
    end
    load_d = sdram_rd2_load;
  endtask

  // Runs until DONE; en is dropped once stop_bytes bytes have been accepted.
  task automatic run_frame(input int stop_bytes);
    int cyc;
    int n_pix;
    int n_chk;
    cyc = 0;
    while (st() != 32'd7 && cyc < BUDGET) begin
      step();
      cyc++;
      if (got_q.size() >= stop_bytes) en = 1'b0;
    end
    check("frame_in_budget", 32'(cyc < BUDGET), 32'd1);
    step();
    check("rdy_after_done", st(), 32'd0);
    n_pix = (stop_bytes + 2) / 3;
    check("byte_count", 32'(got_q.size()), 32'(3 * n_pix));
    check("pop_count", 32'(pop_idx), 32'(n_pix));
    n_chk = (got_q.size() < 3 * n_pix) ? got_q.size() : 3 * n_pix;
    for (int i = 0; i < n_chk; i++)
      check("byte", 32'(got_q[i]), 32'(exp_byte(pix[i / 3], i % 3)));
  endtask

  initial begin
    int cyc;
    vec_cnt        = 0;
    err_cnt        = 0;
    rst_n          = 1'b0;
    en             = 1'b0;
    sdram_rd2_data = 10'd0;
    READ_Request   = 1'b0;
    VGA_HS         = 1'b0;
    VGA_VS         = 1'b0;
    init_model();
    repeat (3) @(negedge clk);
    check("rst_state", st(), 32'd0);
    check("rst_load", 32'(sdram_rd2_load), 32'd0);
    check("rst_txen", 32'(txEn), 32'd0);
    check("rst_txstart", 32'(txStart), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);

    // Full frame with corner pixel values at the front.
    pix[0] = 10'd5;
    pix[1] = 10'h0FF;
    pix[2] = 10'h3FE;
    rst_n  = 1'b1;
    en     = 1'b1;
    step();
    check("first_read", st(), 32'd1);
    check("first_load", 32'(sdram_rd2_load), 32'd1);
    step();
    check("first_wait_read", st(), 32'd2);
    check("load_one_cycle", 32'(sdram_rd2_load), 32'd0);
    run_frame(3 * TOTAL);

    // en dropped at a random byte: the pixel in flight finishes, then stop.
    init_model();
    en = 1'b1;
    run_frame($urandom_range(1, 3 * TOTAL - 1));

    // en dropped exactly as the first Blue is accepted.
    init_model();
    en = 1'b1;
    run_frame(3);

    // Reset asserted in WAIT_SEND clears state and tx outputs at once.
    init_model();
    en  = 1'b1;
    cyc = 0;
    while (st() != 32'd6 && cyc < BUDGET) begin
      step();
      cyc++;
    end
    check("reach_wait_send", st(), 32'd6);
    rst_n = 1'b0;
    #1;
    check("midrst_state", st(), 32'd0);
    check("midrst_txstart", 32'(txStart), 32'd0);
    check("midrst_txen", 32'(txEn), 32'd0);
    check("midrst_txdata", 32'(tx_data), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", st(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
